// File: rtl/sdram_arbiter.sv
// Two-requester front end for the SDRAM controller command port: video bursts
// have priority, host single-word access is protected by a streak limit.
module sdram_arbiter #(
    parameter int ADDR_WIDTH       = 22,
    parameter int DATA_WIDTH       = 16,
    parameter int BURST_LEN        = 8,
    parameter int MAX_VIDEO_STREAK = 4
) (
    input  logic                  clk_mem,
    input  logic                  reset,
    input  logic                  video_req,
    input  logic [ADDR_WIDTH-1:0] video_addr,
    output logic                  video_ack,
    output logic [DATA_WIDTH-1:0] video_rdata,
    output logic                  video_rvalid,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_ack,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  host_rvalid,
    output logic                  mem_cmd_valid,
    input  logic                  mem_cmd_ready,
    output logic                  mem_cmd_we,
    output logic [ADDR_WIDTH-1:0] mem_cmd_addr,
    output logic [8:0]            mem_cmd_len,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvalid,
    output logic                  protocol_err
);

    // state | meaning
    // IDLE  | arbitrate; requests are only sampled here
    // CMD   | captured command presented until the controller takes it
    // DATA  | forwarding read beats to the owner until the count expires
    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    localparam logic [8:0] BURST_LEN_W = 9'(BURST_LEN);
    localparam logic [3:0] STREAK_MAX  = 4'(MAX_VIDEO_STREAK);

    state_t     state, state_nxt;
    logic       owner_host;
    logic [8:0] beats;
    logic [3:0] streak;
    logic       host_win, video_win, accept, beat_in, last_beat;

    always_comb begin
        host_win  = host_req && (!video_req || streak == STREAK_MAX);
        video_win = video_req && !host_win;
        accept    = (state == CMD) && mem_cmd_ready;
        beat_in   = (state == DATA) && mem_rvalid;
        last_beat = beat_in && (beats == 9'd1);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (host_win || video_win) state_nxt = CMD;
            CMD:  if (accept) state_nxt = mem_cmd_we ? IDLE : DATA;
            DATA: if (last_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_mem or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    assign mem_cmd_valid = (state == CMD);
    assign video_ack     = accept && !owner_host;
    assign host_ack      = accept && owner_host;

    // Command capture and streak tracking happen only while arbitrating.
    always_ff @(posedge clk_mem or posedge reset) begin
        if (reset) begin
            owner_host   <= 1'b0;
            mem_cmd_we   <= 1'b0;
            mem_cmd_addr <= '0;
            mem_cmd_len  <= '0;
            mem_wdata    <= '0;
            streak       <= '0;
        end else if (state == IDLE) begin
            if (host_win) begin
                owner_host   <= 1'b1;
                mem_cmd_we   <= host_we;
                mem_cmd_addr <= host_addr;
                mem_cmd_len  <= 9'd1;
                mem_wdata    <= host_wdata;
            end else if (video_win) begin
                owner_host   <= 1'b0;
                mem_cmd_we   <= 1'b0;
                mem_cmd_addr <= video_addr;
                mem_cmd_len  <= BURST_LEN_W;
            end
            if (!host_req || host_win)
                streak <= '0;
            else if (video_win && streak != STREAK_MAX)
                streak <= streak + 4'd1;
        end
    end

    // Read return path: one register stage, steered by the captured owner.
    always_ff @(posedge clk_mem or posedge reset) begin
        if (reset) begin
            beats        <= '0;
            video_rvalid <= 1'b0;
            video_rdata  <= '0;
            host_rvalid  <= 1'b0;
            host_rdata   <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (accept)
                beats <= mem_cmd_len;
            else if (beat_in)
                beats <= beats - 9'd1;
            video_rvalid <= beat_in && !owner_host;
            host_rvalid  <= beat_in && owner_host;
            if (beat_in && !owner_host) video_rdata <= mem_rdata;
            if (beat_in && owner_host)  host_rdata  <= mem_rdata;
            if (mem_rvalid && state != DATA)
                protocol_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: transaction-level scoreboard of expected
// commands and read beats, checked every cycle, plus literal spot checks.
module tb_sdram_arbiter;
    localparam int AW   = 22;
    localparam int DW   = 16;
    localparam int MAXS = 4;

    logic          clk_mem = 1'b0;
    logic          reset = 1'b1;
    logic          video_req = 1'b0;
    logic [AW-1:0] video_addr = '0;
    logic          video_ack;
    logic [DW-1:0] video_rdata;
    logic          video_rvalid;
    logic          host_req = 1'b0;
    logic          host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          host_ack;
    logic [DW-1:0] host_rdata;
    logic          host_rvalid;
    logic          mem_cmd_valid;
    logic          mem_cmd_ready = 1'b0;
    logic          mem_cmd_we;
    logic [AW-1:0] mem_cmd_addr;
    logic [8:0]    mem_cmd_len;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_rvalid = 1'b0;
    logic          protocol_err;

    sdram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(8), .MAX_VIDEO_STREAK(MAXS)) dut (
        .clk_mem(clk_mem), .reset(reset),
        .video_req(video_req), .video_addr(video_addr), .video_ack(video_ack),
        .video_rdata(video_rdata), .video_rvalid(video_rvalid),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .host_rvalid(host_rvalid), .mem_cmd_valid(mem_cmd_valid),
        .mem_cmd_ready(mem_cmd_ready), .mem_cmd_we(mem_cmd_we),
        .mem_cmd_addr(mem_cmd_addr), .mem_cmd_len(mem_cmd_len),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .protocol_err(protocol_err)
    );

    always #5 clk_mem = ~clk_mem;

    typedef struct {
        logic          host;
        logic          we;
        logic [AW-1:0] addr;
        logic [8:0]    len;
        logic [DW-1:0] wdata;
    } cmd_t;

    typedef struct {
        logic          host;
        logic [DW-1:0] data;
        int            cyc;
    } beat_t;

    cmd_t          exp_cmd[$];
    beat_t         exp_beat[$];
    string         grant_log = "";
    int            vectors = 0;
    int            miscompares = 0;
    int            cyc = 0;
    logic          exp_perr = 1'b0;
    logic [DW-1:0] last_v = '0;
    logic [DW-1:0] last_h = '0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void check_str(string name, string act, string exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %s expected %s", name, act, exp);
        end
    endfunction

    task automatic push_cmd(input logic host, input logic we, input logic [AW-1:0] addr,
                            input logic [8:0] len, input logic [DW-1:0] wdata);
        exp_cmd.push_back('{host, we, addr, len, wdata});
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_ctl"}, 64'({video_ack, video_rvalid, host_ack, host_rvalid, mem_cmd_valid,
                                  mem_cmd_we, protocol_err, mem_cmd_len}), 64'd0);
        check({tag, "_data"}, 64'({video_rdata, host_rdata, mem_wdata}), 64'd0);
        check({tag, "_addr"}, 64'(mem_cmd_addr), 64'd0);
    endtask

    // Controller model: accept after rdy_dly cycles, then return nbeats beats.
    task automatic serve(input int rdy_dly, input int gap_max, input int nbeats, input logic host,
                         input logic [DW-1:0] base, input logic [1:0] drop, input bit scramble);
        int t;
        int gap;
        t = 0;
        while (!mem_cmd_valid && t < 60) begin
            @(posedge clk_mem); #1;
            t++;
        end
        if (!mem_cmd_valid) begin
            vectors++;
            miscompares++;
            $display("FAIL cmd_timeout: got no mem_cmd_valid within 60 cycles (cycle %0d)", cyc);
            return;
        end
        for (int i = 0; i < rdy_dly; i++) begin
            if (scramble) begin
                video_addr = AW'($urandom);
                host_addr  = AW'($urandom);
            end
            @(posedge clk_mem); #1;
        end
        mem_cmd_ready = 1'b1;
        @(posedge clk_mem); #1;
        mem_cmd_ready = 1'b0;
        if (drop[0]) video_req = 1'b0;
        if (drop[1]) host_req = 1'b0;
        check("valid_drop", 64'(mem_cmd_valid), 64'd0);
        for (int i = 0; i < nbeats; i++) begin
            gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (gap) begin @(posedge clk_mem); #1; end
            mem_rdata  = base + DW'(i);
            mem_rvalid = 1'b1;
            exp_beat.push_back('{host, base + DW'(i), cyc});
            @(posedge clk_mem); #1;
            mem_rvalid = 1'b0;
        end
    endtask

    initial forever begin
        @(posedge clk_mem);
        cyc++;
    end

    // Per-cycle compare against the scoreboard.
    initial forever begin
        @(negedge clk_mem);
        if (!reset) begin
            if (mem_cmd_valid) begin
                if (exp_cmd.size() == 0) begin
                    check("unexpected_cmd", 64'(mem_cmd_valid), 64'd0);
                end else begin
                    check("cmd_we", 64'(mem_cmd_we), 64'(exp_cmd[0].we));
                    check("cmd_addr", 64'(mem_cmd_addr), 64'(exp_cmd[0].addr));
                    check("cmd_len", 64'(mem_cmd_len), 64'(exp_cmd[0].len));
                    if (exp_cmd[0].we) check("cmd_wdata", 64'(mem_wdata), 64'(exp_cmd[0].wdata));
                    if (mem_cmd_ready) begin
                        check("video_ack", 64'(video_ack), 64'(!exp_cmd[0].host));
                        check("host_ack", 64'(host_ack), 64'(exp_cmd[0].host));
                        if (video_ack) grant_log = {grant_log, "V"};
                        if (host_ack)  grant_log = {grant_log, "H"};
                        void'(exp_cmd.pop_front());
                    end else begin
                        check("ack_stall", 64'({video_ack, host_ack}), 64'd0);
                    end
                end
            end else begin
                check("ack_idle", 64'({video_ack, host_ack}), 64'd0);
            end
            if (video_rvalid) begin
                if (exp_beat.size() == 0 || exp_beat[0].host) begin
                    check("video_stray_rvalid", 64'(video_rvalid), 64'd0);
                end else begin
                    check("video_rdata", 64'(video_rdata), 64'(exp_beat[0].data));
                    check("video_latency", 64'(cyc), 64'(exp_beat[0].cyc + 1));
                    void'(exp_beat.pop_front());
                end
                last_v = video_rdata;
            end else begin
                check("video_rdata_hold", 64'(video_rdata), 64'(last_v));
            end
            if (host_rvalid) begin
                if (exp_beat.size() == 0 || !exp_beat[0].host) begin
                    check("host_stray_rvalid", 64'(host_rvalid), 64'd0);
                end else begin
                    check("host_rdata", 64'(host_rdata), 64'(exp_beat[0].data));
                    check("host_latency", 64'(cyc), 64'(exp_beat[0].cyc + 1));
                    void'(exp_beat.pop_front());
                end
                last_h = host_rdata;
            end else begin
                check("host_rdata_hold", 64'(host_rdata), 64'(last_h));
            end
            check("protocol_err", 64'(protocol_err), 64'(exp_perr));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1);
    end

    initial begin
        int  s;
        bit  hsel[10];

        // Reset state
        #3;
        check_all_zero("reset_init");
        @(posedge clk_mem); #1;
        reset = 1'b0;

        // Simultaneous first request: video first, host right after
        video_addr = 22'h00400;
        host_addr  = 22'h00077;
        host_we    = 1'b0;
        push_cmd(1'b0, 1'b0, 22'h00400, 9'd8, '0);
        push_cmd(1'b1, 1'b0, 22'h00077, 9'd1, '0);
        video_req = 1'b1;
        host_req  = 1'b1;
        serve(1, 0, 8, 1'b0, 16'hA100, 2'b01, 1'b0);
        serve(0, 0, 1, 1'b1, 16'h5A5A, 2'b10, 1'b0);
        check("host_rdata_lit", 64'(host_rdata), 64'h5A5A);
        check_str("grant_order_simul", grant_log, "VH");
        grant_log = "";

        // Video burst with latency and 2-cycle ready stall
        repeat (2) begin @(posedge clk_mem); #1; end
        video_addr = 22'h00100;
        push_cmd(1'b0, 1'b0, 22'h00100, 9'd8, '0);
        video_req = 1'b1;
        @(negedge clk_mem);
        check("latency_n", 64'(mem_cmd_valid), 64'd0);
        @(negedge clk_mem);
        check("latency_n1", 64'(mem_cmd_valid), 64'd1);
        check("video_len_lit", 64'(mem_cmd_len), 64'd8);
        serve(2, 0, 8, 1'b0, 16'hA000, 2'b01, 1'b0);
        check("video_last_lit", 64'(video_rdata), 64'hA007);

        // Host write, ready immediately
        host_we    = 1'b1;
        host_addr  = 22'h3FFFFF;
        host_wdata = 16'hBEEF;
        push_cmd(1'b1, 1'b1, 22'h3FFFFF, 9'd1, 16'hBEEF);
        host_req = 1'b1;
        serve(0, 0, 0, 1'b1, '0, 2'b10, 1'b0);
        check("wdata_lit", 64'(mem_wdata), 64'hBEEF);
        @(negedge clk_mem);
        check("write_idle", 64'({mem_cmd_valid, host_rvalid}), 64'd0);
        host_we = 1'b0;

        // Starvation bound: both held, expected order from the streak rule
        video_addr = 22'h02000;
        host_addr  = 22'h00055;
        s = 0;
        for (int g = 0; g < 10; g++) begin
            hsel[g] = (s == MAXS);
            if (hsel[g]) begin
                push_cmd(1'b1, 1'b0, 22'h00055, 9'd1, '0);
                s = 0;
            end else begin
                push_cmd(1'b0, 1'b0, 22'h02000, 9'd8, '0);
                s++;
            end
        end
        grant_log = "";
        video_req = 1'b1;
        host_req  = 1'b1;
        for (int g = 0; g < 10; g++) begin
            serve(g % 3, 0, hsel[g] ? 1 : 8, hsel[g], hsel[g] ? DW'(16'hC000 + g) : DW'(16'hB000 + g * 16),
                  (g == 9) ? 2'b11 : 2'b00, 1'b0);
        end
        check_str("grant_order_streak", grant_log, "VVVVHVVVVH");
        check("host_read_lit", 64'(host_rdata), 64'hC009);

        // Gapped beats, ready stalls, requester address churn during CMD
        for (int b = 0; b < 3; b++) begin
            video_addr = AW'(22'h10000 + b * 22'h40);
            push_cmd(1'b0, 1'b0, AW'(22'h10000 + b * 22'h40), 9'd8, '0);
            video_req = 1'b1;
            serve(int'($urandom_range(10, 0)), 4, 8, 1'b0, DW'(16'hD000 + b * 8), 2'b01, 1'b1);
        end
        check("gapped_last_lit", 64'(video_rdata), 64'hD017);
        check("gapped_perr_lit", 64'(protocol_err), 64'd0);

        // Reset mid-DATA after 3 of 8 beats
        video_addr = 22'h03000;
        push_cmd(1'b0, 1'b0, 22'h03000, 9'd8, '0);
        video_req = 1'b1;
        serve(1, 0, 3, 1'b0, 16'hE000, 2'b01, 1'b0);
        @(negedge clk_mem);
        check("pre_reset_lit", 64'(video_rdata), 64'hE002);
        #2;
        reset = 1'b1;
        exp_cmd.delete();
        exp_beat.delete();
        exp_perr = 1'b0;
        last_v = '0;
        last_h = '0;
        #1;
        check_all_zero("reset_mid");
        repeat (2) @(posedge clk_mem);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem_rdata  = DW'(16'hE003 + i);
            mem_rvalid = 1'b1;
            @(posedge clk_mem); #1;
            exp_perr = 1'b1;
        end
        mem_rvalid = 1'b0;
        check("stray_perr_lit", 64'(protocol_err), 64'd1);
        video_addr = 22'h00800;
        push_cmd(1'b0, 1'b0, 22'h00800, 9'd8, '0);
        video_req = 1'b1;
        serve(0, 1, 8, 1'b0, 16'hF000, 2'b01, 1'b0);
        check("post_reset_lit", 64'(video_rdata), 64'hF007);

        repeat (3) @(negedge clk_mem);
        check("beats_pending", 64'(exp_beat.size()), 64'd0);
        check("cmds_pending", 64'(exp_cmd.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
